mcu_assembly_buffer: RTL and testbench

- Parametrised successor to the fixed three-channel buffer.
- Collects decoded 8x8 blocks of one MCU, tagged with a channel, between the supersample/IDCT stage and YCbCr_to_RGB_8x8.
- Supports 4:4:4, 4:2:2, 4:2:0 and grayscale through a mode input, with nearest-neighbour chroma upsampling inside the block.
- Emits one (Y, Cb, Cr) 8x8 triplet per luma block under valid/ready backpressure in both directions.

---
 rtl/jpeg_mcu_pkg.sv | 38 +++
 rtl/chroma_upsample_8x8.sv | 40 ++++
 rtl/mcu_assembly_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_mcu_assembly_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_mcu_pkg.sv
// Shared types and helpers for the MCU assembly buffer: subsampling modes,
// channel tags, collector states and the luma-blocks-per-MCU lookup.
package jpeg_mcu_pkg;

   typedef enum logic [1:0] {
      SS_444  = 2'd0,
      SS_422  = 2'd1,
      SS_420  = 2'd2,
      SS_GRAY = 2'd3
   } subsample_mode_e;

   typedef enum logic [1:0] {
      CH_Y  = 2'd0,
      CH_CB = 2'd1,
      CH_CR = 2'd2
   } channel_e;

   typedef enum logic [1:0] {
      COL_Y  = 2'd0,
      COL_CB = 2'd1,
      COL_CR = 2'd2,
      EMIT   = 2'd3
   } buf_state_e;

   // Number of luma 8x8 blocks that make up one MCU in the given mode.
   function automatic logic [2:0] ny_for_mode(input subsample_mode_e m);
      logic [2:0] ny;
      case (m)
         SS_444:  ny = 3'd1;
         SS_422:  ny = 3'd2;
         SS_420:  ny = 3'd4;
         SS_GRAY: ny = 3'd1;
         default: ny = 3'd1;
      endcase
      return ny;
   endfunction

endpackage

// File: rtl/chroma_upsample_8x8.sv
// Nearest-neighbour chroma upsampler: selects the quadrant/half of a stored
// chroma block that covers luma block e and replicates each sample so the
// result lines up 1:1 with the luma block. Grayscale yields a flat fill.
module chroma_upsample_8x8
   import jpeg_mcu_pkg::*;
#(
   parameter int Q = 8
) (
   input  logic [7:0][7:0][Q-1:0] blk_in,
   input  logic [1:0]             mode,
   input  logic [1:0]             e,
   input  logic [Q-1:0]           fill,
   output logic [7:0][7:0][Q-1:0] blk_out
);

   // Map every output element to its source element for the active mode.
   always_comb begin
      logic [2:0] rr;
      logic [2:0] cc;
      rr      = 3'd0;
      cc      = 3'd0;
      blk_out = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            rr = 3'(r);
            cc = 3'(c);
            case (subsample_mode_e'(mode))
               // Full-resolution chroma: straight copy.
               SS_444:  blk_out[r][c] = blk_in[rr][cc];
               // Horizontal half: column = e*4 + c/2.
               SS_422:  blk_out[r][c] = blk_in[rr][{e[0], cc[2:1]}];
               // Quadrant: row = (e>>1)*4 + r/2, column = (e&1)*4 + c/2.
               SS_420:  blk_out[r][c] = blk_in[{e[1], rr[2:1]}][{e[0], cc[2:1]}];
               default: blk_out[r][c] = fill;
            endcase
         end
      end
   end

endmodule

// File: rtl/mcu_assembly_buffer.sv
// MCU assembly buffer: collects the Y, Cb and Cr 8x8 blocks of one MCU and
// then emits one upsampled (Y, Cb, Cr) triplet per luma block, with
// valid/ready flow control on both sides. Blocks carrying an unexpected
// channel tag are dropped and flagged on a sticky order_err.
module mcu_assembly_buffer
   import jpeg_mcu_pkg::*;
#(
   parameter int         Q         = 8,
   parameter int         MAX_Y     = 4,
   parameter int         CH_W      = 2,
   parameter logic [7:0] GRAY_FILL = 8'd128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             mode,
   input  logic [7:0][7:0][Q-1:0] block_in,
   input  logic [CH_W-1:0]        ch_in,
   input  logic                   valid_in,
   output logic                   ready_in,
   output logic [7:0][7:0][Q-1:0] y_out,
   output logic [7:0][7:0][Q-1:0] cb_out,
   output logic [7:0][7:0][Q-1:0] cr_out,
   output logic [1:0]             blk_idx,
   output logic                   mcu_last,
   output logic                   valid_out,
   input  logic                   ready_out,
   output logic                   order_err
);

   localparam int         AW     = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;
   localparam int         YW     = $clog2(MAX_Y + 1);
   localparam logic [Q-1:0] GRAY_Q = Q'(GRAY_FILL);

   // Registered state and storage
   buf_state_e             state_r;
   subsample_mode_e        mode_r;
   logic [YW-1:0]          y_cnt_r;
   logic [1:0]             e_r;
   logic                   order_err_r;
   logic                   valid_r;
   logic                   last_r;
   logic [7:0][7:0][Q-1:0] ybuf_r [MAX_Y];
   logic [7:0][7:0][Q-1:0] cbuf_r;
   logic [7:0][7:0][Q-1:0] crbuf_r;

   // Next-state and control signals
   buf_state_e             state_next_s;
   subsample_mode_e        mode_next_s;
   subsample_mode_e        eff_mode_s;
   logic [YW-1:0]          y_cnt_next_s;
   logic [YW-1:0]          y_inc_s;
   logic [1:0]             e_next_s;
   logic                   order_err_next_s;
   logic                   valid_next_s;
   logic                   last_next_s;
   logic [2:0]             ny_eff_s;
   logic [2:0]             ny_cur_s;
   logic [2:0]             ny_next_s;
   logic                   accept_s;
   logic                   wr_y_s;
   logic                   wr_cb_s;
   logic                   wr_cr_s;
   logic                   ready_in_s;

   // Input side is open whenever nothing stored is waiting to be emitted.
   assign ready_in_s = (state_r != EMIT);
   assign accept_s   = valid_in && ready_in_s;

   // The mode is only taken from the port on the first luma block of an MCU.
   assign eff_mode_s = (y_cnt_r == '0) ? subsample_mode_e'(mode) : mode_r;
   assign ny_eff_s   = ny_for_mode(eff_mode_s);
   assign ny_cur_s   = ny_for_mode(mode_r);
   assign y_inc_s    = y_cnt_r + YW'(1);

   // Collector/emitter FSM next-state logic and storage write strobes.
   always_comb begin
      state_next_s     = state_r;
      mode_next_s      = mode_r;
      y_cnt_next_s     = y_cnt_r;
      e_next_s         = e_r;
      order_err_next_s = order_err_r;
      wr_y_s           = 1'b0;
      wr_cb_s          = 1'b0;
      wr_cr_s          = 1'b0;
      case (state_r)
         COL_Y: begin
            if (accept_s) begin
               if (ch_in == CH_W'(CH_Y)) begin
                  wr_y_s       = 1'b1;
                  mode_next_s  = eff_mode_s;
                  y_cnt_next_s = y_inc_s;
                  if (y_inc_s == YW'(ny_eff_s)) begin
                     if (eff_mode_s == SS_GRAY) begin
                        state_next_s = EMIT;
                     end else begin
                        state_next_s = COL_CB;
                     end
                  end else begin
                     state_next_s = COL_Y;
                  end
               end else begin
                  order_err_next_s = 1'b1;
               end
            end else begin
               state_next_s = COL_Y;
            end
         end
         COL_CB: begin
            if (accept_s) begin
               if (ch_in == CH_W'(CH_CB)) begin
                  wr_cb_s      = 1'b1;
                  state_next_s = COL_CR;
               end else begin
                  order_err_next_s = 1'b1;
               end
            end else begin
               state_next_s = COL_CB;
            end
         end
         COL_CR: begin
            if (accept_s) begin
               if (ch_in == CH_W'(CH_CR)) begin
                  wr_cr_s      = 1'b1;
                  state_next_s = EMIT;
               end else begin
                  order_err_next_s = 1'b1;
               end
            end else begin
               state_next_s = COL_CR;
            end
         end
         EMIT: begin
            if (ready_out) begin
               if ({1'b0, e_r} == (ny_cur_s - 3'd1)) begin
                  state_next_s = COL_Y;
                  e_next_s     = 2'd0;
                  y_cnt_next_s = '0;
               end else begin
                  e_next_s = e_r + 2'd1;
               end
            end else begin
               state_next_s = EMIT;
            end
         end
         default: begin
            state_next_s = COL_Y;
            e_next_s     = 2'd0;
            y_cnt_next_s = '0;
         end
      endcase
   end

   // Output flags are precomputed from next-state so they leave a register.
   always_comb begin
      ny_next_s    = ny_for_mode(mode_next_s);
      valid_next_s = (state_next_s == EMIT);
      if (state_next_s == EMIT) begin
         last_next_s = ({1'b0, e_next_s} == (ny_next_s - 3'd1));
      end else begin
         last_next_s = 1'b0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= COL_Y;
         mode_r      <= SS_444;
         y_cnt_r     <= '0;
         e_r         <= 2'd0;
         order_err_r <= 1'b0;
         valid_r     <= 1'b0;
         last_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         mode_r      <= mode_next_s;
         y_cnt_r     <= y_cnt_next_s;
         e_r         <= e_next_s;
         order_err_r <= order_err_next_s;
         valid_r     <= valid_next_s;
         last_r      <= last_next_s;
      end
   end

   // Block storage: luma blocks by arrival index, one Cb and one Cr block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_Y; i++) begin
            ybuf_r[i] <= '0;
         end
         cbuf_r  <= '0;
         crbuf_r <= '0;
      end else begin
         if (wr_y_s) begin
            ybuf_r[y_cnt_r[AW-1:0]] <= block_in;
         end
         if (wr_cb_s) begin
            cbuf_r <= block_in;
         end
         if (wr_cr_s) begin
            crbuf_r <= block_in;
         end
      end
   end

   chroma_upsample_8x8 #(.Q(Q)) u_cb_up (
      .blk_in  (cbuf_r),
      .mode    (mode_r),
      .e       (e_r),
      .fill    (GRAY_Q),
      .blk_out (cb_out)
   );

   chroma_upsample_8x8 #(.Q(Q)) u_cr_up (
      .blk_in  (crbuf_r),
      .mode    (mode_r),
      .e       (e_r),
      .fill    (GRAY_Q),
      .blk_out (cr_out)
   );

   assign y_out     = ybuf_r[e_r[AW-1:0]];
   assign ready_in  = ready_in_s;
   assign blk_idx   = e_r;
   assign mcu_last  = last_r;
   assign valid_out = valid_r;
   assign order_err = order_err_r;

endmodule

// File: tb/tb_mcu_assembly_buffer.sv
// Directed self-checking bench for mcu_assembly_buffer.
module tb_mcu_assembly_buffer;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             mode;
   logic [7:0][7:0][7:0]   block_in;
   logic [1:0]             ch_in;
   logic                   valid_in;
   logic                   ready_in;
   logic [7:0][7:0][7:0]   y_out;
   logic [7:0][7:0][7:0]   cb_out;
   logic [7:0][7:0][7:0]   cr_out;
   logic [1:0]             blk_idx;
   logic                   mcu_last;
   logic                   valid_out;
   logic                   ready_out;
   logic                   order_err;

   int n_cmp = 0;
   int n_bad = 0;

   mcu_assembly_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .block_in  (block_in),
      .ch_in     (ch_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .y_out     (y_out),
      .cb_out    (cb_out),
      .cr_out    (cr_out),
      .blk_idx   (blk_idx),
      .mcu_last  (mcu_last),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .order_err (order_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0][7:0][7:0] const_blk(input logic [7:0] v);
      logic [7:0][7:0][7:0] b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r][c] = v;
      return b;
   endfunction

   function automatic logic [7:0][7:0][7:0] ramp_blk();
      logic [7:0][7:0][7:0] b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b[r][c] = 8'(r * 8 + c);
      return b;
   endfunction

   // Offer one block for a single cycle; returns at posedge + 1.
   task automatic drive(input logic [1:0] ch, input logic [1:0] m,
                        input logic [7:0][7:0][7:0] b);
      @(negedge clk);
      mode     = m;
      ch_in    = ch;
      block_in = b;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      mode      = 2'd0;
      ch_in     = 2'd0;
      block_in  = '0;
      valid_in  = 1'b0;
      ready_out = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", order_err); end
      n_cmp++; if (blk_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", blk_idx); end
      n_cmp++; if (mcu_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", mcu_last); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_in); end
   endtask

   task automatic test_420();
      int cb00 [4] = '{0, 4, 32, 36};
      int cb77 [4] = '{27, 31, 59, 63};
      ready_out = 1'b1;
      drive(2'd0, 2'd2, const_blk(8'd10));
      drive(2'd0, 2'd2, const_blk(8'd20));
      drive(2'd0, 2'd2, const_blk(8'd30));
      drive(2'd0, 2'd2, const_blk(8'd40));
      drive(2'd1, 2'd2, ramp_blk());
      drive(2'd2, 2'd2, const_blk(8'd200));
      for (int e = 0; e < 4; e++) begin
         n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL s420_valid e=%0d: got %b want 1", e, valid_out); end
         n_cmp++; if (blk_idx !== 2'(e)) begin n_bad++; $display("FAIL s420_idx: got %0d want %0d", blk_idx, e); end
         n_cmp++; if (y_out[4][4] !== 8'((e + 1) * 10)) begin n_bad++; $display("FAIL s420_y e=%0d: got %0d want %0d", e, y_out[4][4], (e + 1) * 10); end
         n_cmp++; if (cb_out[0][0] !== 8'(cb00[e])) begin n_bad++; $display("FAIL s420_cb00 e=%0d: got %0d want %0d", e, cb_out[0][0], cb00[e]); end
         n_cmp++; if (cb_out[7][7] !== 8'(cb77[e])) begin n_bad++; $display("FAIL s420_cb77 e=%0d: got %0d want %0d", e, cb_out[7][7], cb77[e]); end
         n_cmp++; if (cr_out[3][6] !== 8'd200) begin n_bad++; $display("FAIL s420_cr e=%0d: got %0d want 200", e, cr_out[3][6]); end
         n_cmp++; if (mcu_last !== (e == 3)) begin n_bad++; $display("FAIL s420_last e=%0d: got %b want %b", e, mcu_last, (e == 3)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL s420_end_valid: got %b want 0", valid_out); end
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL s420_end_ready: got %b want 1", ready_in); end
   endtask

   task automatic test_422();
      int cb50 [2] = '{40, 44};
      int cb57 [2] = '{43, 47};
      ready_out = 1'b1;
      drive(2'd0, 2'd1, const_blk(8'd50));
      drive(2'd0, 2'd1, const_blk(8'd60));
      drive(2'd1, 2'd1, ramp_blk());
      drive(2'd2, 2'd1, const_blk(8'd90));
      for (int e = 0; e < 2; e++) begin
         n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL s422_valid e=%0d: got %b want 1", e, valid_out); end
         n_cmp++; if (y_out[0][0] !== 8'(50 + 10 * e)) begin n_bad++; $display("FAIL s422_y e=%0d: got %0d want %0d", e, y_out[0][0], 50 + 10 * e); end
         n_cmp++; if (cb_out[5][0] !== 8'(cb50[e])) begin n_bad++; $display("FAIL s422_cb50 e=%0d: got %0d want %0d", e, cb_out[5][0], cb50[e]); end
         n_cmp++; if (cb_out[5][7] !== 8'(cb57[e])) begin n_bad++; $display("FAIL s422_cb57 e=%0d: got %0d want %0d", e, cb_out[5][7], cb57[e]); end
         n_cmp++; if (cr_out[0][0] !== 8'd90) begin n_bad++; $display("FAIL s422_cr e=%0d: got %0d want 90", e, cr_out[0][0]); end
         n_cmp++; if (mcu_last !== (e == 1)) begin n_bad++; $display("FAIL s422_last e=%0d: got %b want %b", e, mcu_last, (e == 1)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL s422_count: got valid %b want 0", valid_out); end
   endtask

   task automatic test_gray();
      ready_out = 1'b1;
      drive(2'd0, 2'd3, const_blk(8'd77));
      n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL gray_valid: got %b want 1", valid_out); end
      n_cmp++; if (y_out[6][1] !== 8'd77) begin n_bad++; $display("FAIL gray_y: got %0d want 77", y_out[6][1]); end
      n_cmp++; if (cb_out[2][3] !== 8'd128) begin n_bad++; $display("FAIL gray_cb: got %0d want 128", cb_out[2][3]); end
      n_cmp++; if (cr_out[7][0] !== 8'd128) begin n_bad++; $display("FAIL gray_cr: got %0d want 128", cr_out[7][0]); end
      n_cmp++; if (mcu_last !== 1'b1) begin n_bad++; $display("FAIL gray_last: got %b want 1", mcu_last); end
      n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL gray_ready_emit: got %b want 0", ready_in); end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL gray_done: got %b want 0", valid_out); end
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL gray_ready_after: got %b want 1", ready_in); end
   endtask

   task automatic test_backpressure();
      ready_out = 1'b0;
      drive(2'd0, 2'd0, const_blk(8'd5));
      drive(2'd1, 2'd0, ramp_blk());
      drive(2'd2, 2'd0, const_blk(8'd9));
      @(negedge clk);
      mode     = 2'd0;
      ch_in    = 2'd0;
      block_in = const_blk(8'd99);
      valid_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL bp_valid c=%0d: got %b want 1", i, valid_out); end
         n_cmp++; if (y_out[3][3] !== 8'd5) begin n_bad++; $display("FAIL bp_y c=%0d: got %0d want 5", i, y_out[3][3]); end
         n_cmp++; if (cb_out[2][6] !== 8'd22) begin n_bad++; $display("FAIL bp_cb c=%0d: got %0d want 22", i, cb_out[2][6]); end
         n_cmp++; if (cr_out[1][1] !== 8'd9) begin n_bad++; $display("FAIL bp_cr c=%0d: got %0d want 9", i, cr_out[1][1]); end
         n_cmp++; if (ready_in !== 1'b0) begin n_bad++; $display("FAIL bp_ready c=%0d: got %b want 0", i, ready_in); end
      end
      @(negedge clk);
      ready_out = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", valid_out); end
      @(posedge clk); #1;
      valid_in = 1'b0;
      drive(2'd1, 2'd0, const_blk(8'd1));
      drive(2'd2, 2'd0, const_blk(8'd2));
      n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid: got %b want 1", valid_out); end
      n_cmp++; if (y_out[0][0] !== 8'd99) begin n_bad++; $display("FAIL bp_next_y: got %0d want 99", y_out[0][0]); end
      n_cmp++; if (cb_out[4][4] !== 8'd1) begin n_bad++; $display("FAIL bp_next_cb: got %0d want 1", cb_out[4][4]); end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL bp_next_done: got %b want 0", valid_out); end
      n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL bp_no_err: got %b want 0", order_err); end
   endtask

   task automatic test_order_err();
      ready_out = 1'b1;
      drive(2'd0, 2'd0, const_blk(8'd11));
      drive(2'd2, 2'd0, const_blk(8'd55));
      n_cmp++; if (order_err !== 1'b1) begin n_bad++; $display("FAIL ord_set: got %b want 1", order_err); end
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL ord_no_emit: got %b want 0", valid_out); end
      drive(2'd1, 2'd0, ramp_blk());
      drive(2'd2, 2'd0, const_blk(8'd66));
      n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL ord_valid: got %b want 1", valid_out); end
      n_cmp++; if (y_out[2][2] !== 8'd11) begin n_bad++; $display("FAIL ord_y: got %0d want 11", y_out[2][2]); end
      n_cmp++; if (cb_out[1][1] !== 8'd9) begin n_bad++; $display("FAIL ord_cb: got %0d want 9", cb_out[1][1]); end
      n_cmp++; if (cr_out[0][0] !== 8'd66) begin n_bad++; $display("FAIL ord_cr: got %0d want 66", cr_out[0][0]); end
      @(posedge clk); #1;
      n_cmp++; if (order_err !== 1'b1) begin n_bad++; $display("FAIL ord_sticky: got %b want 1", order_err); end
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL ord_done: got %b want 0", valid_out); end
   endtask

   task automatic test_reset_mid();
      ready_out = 1'b1;
      drive(2'd0, 2'd2, const_blk(8'd1));
      drive(2'd0, 2'd2, const_blk(8'd2));
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", valid_out); end
      n_cmp++; if (order_err !== 1'b0) begin n_bad++; $display("FAIL rmid_err: got %b want 0", order_err); end
      n_cmp++; if (blk_idx !== 2'd0) begin n_bad++; $display("FAIL rmid_idx: got %0d want 0", blk_idx); end
      n_cmp++; if (mcu_last !== 1'b0) begin n_bad++; $display("FAIL rmid_last: got %b want 0", mcu_last); end
      n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", ready_in); end
      n_cmp++; if (y_out[0][0] !== 8'd0) begin n_bad++; $display("FAIL rmid_ybuf: got %0d want 0", y_out[0][0]); end
      @(negedge clk);
      rst = 1'b1;
      drive(2'd0, 2'd0, const_blk(8'd33));
      drive(2'd1, 2'd0, const_blk(8'd44));
      drive(2'd2, 2'd0, const_blk(8'd55));
      n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL rmid_new_valid: got %b want 1", valid_out); end
      n_cmp++; if (y_out[5][5] !== 8'd33) begin n_bad++; $display("FAIL rmid_new_y: got %0d want 33", y_out[5][5]); end
      n_cmp++; if (cb_out[5][5] !== 8'd44) begin n_bad++; $display("FAIL rmid_new_cb: got %0d want 44", cb_out[5][5]); end
      n_cmp++; if (cr_out[5][5] !== 8'd55) begin n_bad++; $display("FAIL rmid_new_cr: got %0d want 55", cr_out[5][5]); end
      n_cmp++; if (mcu_last !== 1'b1) begin n_bad++; $display("FAIL rmid_new_last: got %b want 1", mcu_last); end
      @(posedge clk); #1;
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rmid_new_count: got %b want 0", valid_out); end
   endtask

   initial begin
      test_reset();
      test_420();
      test_422();
      test_gray();
      test_backpressure();
      test_order_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
